multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS-subset core.
- Instructions and data share one external memory port with a req/ready handshake, so wait-states are tolerated.
- One FSM sequences FETCH/DECODE/EXEC/MEM/WB and reuses a single ALU; the register file is internal.
- Debug outputs expose PC, FSM state, halt/illegal flags and a retired-instruction counter for bench visibility.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- REG_COUNT, 32, number of architectural registers; power of 2, 2..32. Register indices are truncated to log2(REG_COUNT) bits. r0 reads 0 and ignores writes.
- CNT_W, 32, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  transfer completes in any cycle with mem_req=1 and mem_ready=1.
- PC  out  32  current instruction address.
- state  out  3  FSM state encoding.
- halted  out  1  core stopped.
- illegal  out  1  stopped on an unknown opcode or funct.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (reset=0 at an edge, including mid-transaction):
  - PC=RESET_PC, state=FETCH, all registers 0, halted=0, illegal=0, retired=0, mem_req=0.
  - Any outstanding transfer is abandoned. No register or memory write occurs on that edge.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC, held stable until ready. On ready, IR<=mem_rdata, go to DECODE.
- DECODE: read rs/rt into A/B latches; sign- or zero-extend imm16 into the IMM latch.
  - halt (op 111111) -> HALT, halted=1, retired+1.
  - Unknown op or funct -> HALT, illegal=1, halted=1, retired unchanged.
- EXEC, by instruction:
  - R-type add/sub/and/or/slt(signed) and sll(A=shamt, B=rt), addi (sign-ext), ori (zero-ext): ALUOut<=result, -> WB.
  - lw/sw: ALUOut<=rs+sext(imm), -> MEM.
  - beq/bne: if taken, PC<=PC+4+(sext(imm)<<2), else PC<=PC+4; retire; -> FETCH.
  - j: PC<={PC+4[31:28], target, 2'b00}; retire; -> FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B; held until ready.
  - sw: on ready, PC<=PC+4, retire, -> FETCH.
  - lw: on ready, MDR<=mem_rdata, -> WB.
- WB: write rd (R-type), rt (addi/ori), or MDR to rt (lw); PC<=PC+4; retire; -> FETCH.
- Latency with zero-wait memory:
  - R/I-ALU 4 cycles, lw 5, sw 4, beq/bne/j 3.
  - Each wait-state adds 1 cycle.
- mem_req is never asserted outside FETCH/MEM. Address, we and wdata do not change while req=1 and ready=0.
- mem_ready with mem_req=0 is ignored.
- HALT is absorbing: mem_req=0 and no state change until reset.
- PC+4 and the branch target wrap modulo 2^32. Addition overflow is ignored (no trap). Misaligned addresses are not checked; low 2 bits are passed through.

Decomposition:
- Package cpu_pkg holds:
  - state enum/localparams;
  - opcode and funct localparams;
  - ALU operation codes.
- Sub-module regfile (parametrised REG_COUNT, 2 async read ports, 1 sync write port, synchronous active-low clear).
- The ALU is inline; the existing ALU block may be instantiated if its op set covers slt/sll.

Test Plan:
- Reset and stall: hold reset=0 for 3 cycles, release with mem_ready=0 -> PC=0, state=0, mem_req=1, mem_addr=0, stable for 5 stall cycles.
- Zero-wait addi sequence:
  - Stimulus: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt.
  - Response: r3=2, retired=4, halted=1, illegal=0, 4+4+4+2=14 cycles from reset release to HALT.
- Store/load with wait-states:
  - Stimulus: sw r1,8(r0) then lw r4,8(r0), with mem_ready delayed 2 cycles on every transfer.
  - Response: write seen at addr 8 with data 5; r4=5; lw takes 9 cycles.
- Branches and jump:
  - Stimulus: beq r1,r1,+2 at PC=0x10; bne r0,r0,+4 at PC=0x1C; j 0x40.
  - Response: PC sequence 0x10 -> 0x1C -> 0x20; j sets PC=0x100.
- r0 protection and illegal opcode:
  - Stimulus: addi r0,r0,7, then opcode 6'b010011.
  - Response: r0 reads 0; illegal=1, halted=1, retired=1, mem_req stays 0.
- Reset mid-MEM:
  - Stimulus: assert reset=0 while a lw waits on mem_ready.
  - Response: next cycle mem_req=0, no register write, PC=RESET_PC, FETCH restarts after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: FSM states, opcodes,
// funct codes and ALU operations.
package cpu_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear. Register 0 is hard-wired to zero.
module regfile #(
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one FSM sequences FETCH/DECODE/EXEC/MEM/WB over
// a shared req/ready memory port and a single ALU.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      PC,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = $clog2(REG_COUNT);

    logic [2:0]       state_q;
    logic [31:0]      pc_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic [31:0] ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q;

    logic [5:0]  op, funct;
    logic        legal, retire;
    logic [31:0] rs_data, rt_data, src2, alu_res, pc_plus4, br_target;
    logic signed [31:0] a_s, src2_s;
    alu_op_t     alu_op;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];

    always_comb begin
        legal = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_HALT: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    regfile #(
        .REG_COUNT(REG_COUNT),
        .AW       (AW)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .raddr1(ir_q[21 +: AW]),
        .raddr2(ir_q[16 +: AW]),
        .rdata1(rs_data),
        .rdata2(rt_data),
        .we    (state_q == S_WB),
        .waddr ((op == OP_RTYPE) ? ir_q[11 +: AW] : ir_q[16 +: AW]),
        .wdata ((op == OP_LW) ? mdr_q : alu_out_q)
    );

    always_comb begin
        alu_op = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLL:  alu_op = ALU_SLL;
                default: alu_op = ALU_ADD;
            endcase
        end else if (op == OP_ORI) begin
            alu_op = ALU_OR;
        end
    end

    assign src2   = (op == OP_RTYPE) ? b_q : imm_q;
    assign a_s    = a_q;
    assign src2_s = src2;

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = a_q - src2;
            ALU_AND: alu_res = a_q & src2;
            ALU_OR:  alu_res = a_q | src2;
            ALU_SLT: alu_res = {31'b0, (a_s < src2_s)};
            ALU_SLL: alu_res = src2 << a_q[4:0];
            default: alu_res = a_q + src2;
        endcase
    end

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE: retire = (op == OP_HALT);
            S_EXEC:   retire = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J);
            S_MEM:    retire = mem_ready && (op == OP_SW);
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state_q)
                S_FETCH: if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_HALT) begin
                        state_q <= S_HALT;
                    end else if (!legal) begin
                        state_q   <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEM;
                        OP_BEQ: begin
                            pc_q    <= (a_q == b_q) ? br_target : pc_plus4;
                            state_q <= S_FETCH;
                        end
                        OP_BNE: begin
                            pc_q    <= (a_q != b_q) ? br_target : pc_plus4;
                            state_q <= S_FETCH;
                        end
                        OP_J: begin
                            pc_q    <= {pc_plus4[31:28], ir_q[25:0], 2'b00};
                            state_q <= S_FETCH;
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_SW) begin
                            pc_q    <= pc_plus4;
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q    <= pc_plus4;
                    state_q <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Datapath latches carry no reset: each is written before any state reads it.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && mem_ready) begin
            ir_q <= mem_rdata;
        end
        if (state_q == S_DECODE) begin
            a_q   <= (op == OP_RTYPE && funct == FN_SLL) ? {27'b0, ir_q[10:6]} : rs_data;
            b_q   <= rt_data;
            imm_q <= (op == OP_ORI) ? {16'b0, ir_q[15:0]} : sext16(ir_q[15:0]);
        end
        if (state_q == S_EXEC) begin
            alu_out_q <= alu_res;
        end
        if (state_q == S_MEM && mem_ready) begin
            mdr_q <= mem_rdata;
        end
    end

    // Request is gated by reset so an in-flight transfer drops in the reset cycle.
    assign mem_req   = reset && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we    = (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? alu_out_q : pc_q;
    assign mem_wdata = b_q;

    assign PC      = pc_q;
    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: wait-state memory model with a
// scoreboard of expected bus transfers plus directed register/timing checks.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [31:0] retired;

    multicycle_cpu dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .PC       (PC),
        .state    (state),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_states = 0;
    bit          stall_data  = 0;
    bit          sb_on       = 0;
    int          ret_cyc [32];
    logic [31:0] pc_ret  [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {OP_J, tgt};
    endfunction

    // Loads one instruction and queues its fetch; call in execution order.
    task automatic put(input logic [31:0] addr, input logic [31:0] instr);
        xfer_t e;
        mem[addr[11:2]] = instr;
        e.we = 1'b0; e.addr = addr; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data);
        xfer_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory responder: decides ready at the falling edge for the next rising edge.
    initial begin : responder
        int    wcnt;
        xfer_t e;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !(stall_data && state == S_MEM) && wcnt >= wait_states) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                wcnt      = 0;
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_extra_xfer", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_we", {31'b0, mem_we}, {31'b0, e.we});
                        chk("sb_addr", mem_addr, e.addr);
                        if (e.we) chk("sb_wdata", mem_wdata, e.data);
                    end
                end
            end else begin
                mem_ready = 1'b0;
                if (mem_req) wcnt++;
                else wcnt = 0;
            end
        end
    end

    task automatic new_test(input int ws);
        reset = 1'b0;
        sb_on = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        exp_q.delete();
        wait_states = ws;
        stall_data  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ret_cyc[i] = 0;
            pc_ret[i]  = '0;
        end
    endtask

    task automatic run_until_halt(input int max_cyc, output int cyc);
        logic [31:0] prev;
        cyc  = 0;
        prev = retired;
        while (cyc < max_cyc && state != S_HALT) begin
            @(posedge clk); #1;
            cyc++;
            if (retired != prev && retired < 32) begin
                ret_cyc[retired[4:0]] = cyc;
                pc_ret[retired[4:0]]  = PC;
            end
            prev = retired;
        end
        if (state != S_HALT) chk("halt_timeout", {29'b0, state}, {29'b0, S_HALT});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        reset = 1'b0;

        // Reset held for 3 cycles, then released into a stalled fetch.
        wait_states = 100000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_pc", PC, 0);
        chk("rst_state", {29'b0, state}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_illegal", {31'b0, illegal}, 0);
        chk("rst_retired", retired, 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_pc", PC, 0);
            chk("stall_state", {29'b0, state}, 0);
            chk("stall_req", {31'b0, mem_req}, 1);
            chk("stall_addr", mem_addr, 0);
            chk("stall_we", {31'b0, mem_we}, 0);
        end

        // Zero-wait ALU sequence ending in halt.
        new_test(0);
        put(32'h00, enc_i(OP_ADDI, 0, 1, 16'd5));
        put(32'h04, enc_i(OP_ADDI, 0, 2, 16'hFFFD));
        put(32'h08, enc_r(1, 2, 3, 0, FN_ADD));
        put(32'h0C, {OP_HALT, 26'b0});
        sb_on = 1'b1;
        reset = 1'b1;
        run_until_halt(100, cyc);
        chk("addi_cycles", cyc, 14);
        chk("addi_r3", dut.u_rf.regs[3], 32'd2);
        chk("addi_retired", retired, 4);
        chk("addi_halted", {31'b0, halted}, 1);
        chk("addi_illegal", {31'b0, illegal}, 0);
        chk("addi_sb_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("halt_absorb_state", {29'b0, state}, {29'b0, S_HALT});
        chk("halt_absorb_req", {31'b0, mem_req}, 0);

        // Store then load with two wait-states on every transfer.
        new_test(2);
        put(32'h00, enc_j(26'h10));
        put(32'h40, enc_i(OP_ADDI, 0, 1, 16'd5));
        put(32'h44, enc_i(OP_SW, 0, 1, 16'd8));
        exp_xfer(1'b1, 32'h8, 32'd5);
        put(32'h48, enc_i(OP_LW, 0, 4, 16'd8));
        exp_xfer(1'b0, 32'h8, 32'd0);
        put(32'h4C, {OP_HALT, 26'b0});
        sb_on = 1'b1;
        reset = 1'b1;
        run_until_halt(200, cyc);
        chk("ls_r4", dut.u_rf.regs[4], 32'd5);
        chk("ls_mem8", mem[2], 32'd5);
        chk("sw_cycles", ret_cyc[3] - ret_cyc[2], 8);
        chk("lw_cycles", ret_cyc[4] - ret_cyc[3], 9);
        chk("ls_retired", retired, 5);
        chk("ls_sb_empty", exp_q.size(), 0);

        // Branches and jump.
        new_test(0);
        put(32'h000, enc_j(26'h4));
        put(32'h010, enc_i(OP_BEQ, 1, 1, 16'd2));
        put(32'h01C, enc_i(OP_BNE, 0, 0, 16'd4));
        put(32'h020, enc_j(26'h40));
        put(32'h100, {OP_HALT, 26'b0});
        sb_on = 1'b1;
        reset = 1'b1;
        run_until_halt(100, cyc);
        chk("j_pc", pc_ret[1], 32'h10);
        chk("beq_taken_pc", pc_ret[2], 32'h1C);
        chk("bne_fall_pc", pc_ret[3], 32'h20);
        chk("j_far_pc", pc_ret[4], 32'h100);
        chk("beq_cycles", ret_cyc[2] - ret_cyc[1], 3);
        chk("br_retired", retired, 5);
        chk("br_sb_empty", exp_q.size(), 0);

        // Remaining ALU ops, results stored to memory for the scoreboard.
        new_test(1);
        put(32'h00, enc_i(OP_ADDI, 0, 1, 16'hFFFD));
        put(32'h04, enc_i(OP_ORI, 0, 2, 16'h8001));
        put(32'h08, enc_r(1, 2, 3, 0, FN_SLT));
        put(32'h0C, enc_r(0, 2, 4, 4, FN_SLL));
        put(32'h10, enc_r(2, 1, 5, 0, FN_SUB));
        put(32'h14, enc_r(2, 4, 6, 0, FN_OR));
        put(32'h18, enc_r(6, 2, 7, 0, FN_AND));
        put(32'h1C, enc_r(2, 1, 8, 0, FN_SLT));
        put(32'h20, enc_i(OP_SW, 0, 3, 16'h200)); exp_xfer(1'b1, 32'h200, 32'h1);
        put(32'h24, enc_i(OP_SW, 0, 4, 16'h204)); exp_xfer(1'b1, 32'h204, 32'h80010);
        put(32'h28, enc_i(OP_SW, 0, 5, 16'h208)); exp_xfer(1'b1, 32'h208, 32'h8004);
        put(32'h2C, enc_i(OP_SW, 0, 6, 16'h20C)); exp_xfer(1'b1, 32'h20C, 32'h88011);
        put(32'h30, enc_i(OP_SW, 0, 7, 16'h210)); exp_xfer(1'b1, 32'h210, 32'h8001);
        put(32'h34, enc_i(OP_SW, 1, 8, 16'h213)); exp_xfer(1'b1, 32'h210, 32'h0);
        put(32'h38, {OP_HALT, 26'b0});
        sb_on = 1'b1;
        reset = 1'b1;
        run_until_halt(400, cyc);
        chk("alu_retired", retired, 15);
        chk("alu_sb_empty", exp_q.size(), 0);

        // r0 protection then an illegal opcode.
        new_test(0);
        put(32'h00, enc_i(OP_ADDI, 0, 0, 16'd7));
        put(32'h04, {6'b010011, 26'h0});
        sb_on = 1'b1;
        reset = 1'b1;
        run_until_halt(100, cyc);
        chk("r0_zero", dut.u_rf.regs[0], 0);
        chk("ill_illegal", {31'b0, illegal}, 1);
        chk("ill_halted", {31'b0, halted}, 1);
        chk("ill_retired", retired, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ill_req", {31'b0, mem_req}, 0);
        end
        chk("ill_sb_empty", exp_q.size(), 0);

        // Reset while a load waits on memory.
        new_test(0);
        mem[2]     = 32'h0000_1234;
        mem[0]     = enc_i(OP_LW, 0, 4, 16'd8);
        mem[1]     = {OP_HALT, 26'b0};
        stall_data = 1'b1;
        reset      = 1'b1;
        cyc = 0;
        while (cyc < 20 && state != S_MEM) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_reach_mem", {29'b0, state}, {29'b0, S_MEM});
        repeat (2) @(posedge clk);
        #1;
        chk("mid_mem_req", {31'b0, mem_req}, 1);
        reset = 1'b0;
        #1;
        chk("mid_req_drop", {31'b0, mem_req}, 0);
        @(posedge clk); #1;
        chk("mid_rst_req", {31'b0, mem_req}, 0);
        chk("mid_rst_pc", PC, 0);
        chk("mid_rst_state", {29'b0, state}, {29'b0, S_FETCH});
        chk("mid_rst_r4", dut.u_rf.regs[4], 0);
        chk("mid_rst_retired", retired, 0);
        stall_data = 1'b0;
        reset      = 1'b1;
        #1;
        chk("mid_restart_req", {31'b0, mem_req}, 1);
        chk("mid_restart_addr", mem_addr, 0);
        run_until_halt(100, cyc);
        chk("mid_restart_r4", dut.u_rf.regs[4], 32'h1234);
        chk("mid_restart_retired", retired, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
